// File: rtl/poly_addsub_stream.sv
// rtl/poly_addsub_stream.sv - two-stage streaming per-lane add/sub, raw wrap or mod-Q reduced
// Stage 1 forms the 18-bit signed sum/difference, stage 2 applies the optional single mod-Q correction.
module poly_addsub_stream #(
   parameter int KYBER_N   = 256,
   parameter int KYBER_Q   = 3329,
   parameter int LANES     = 8,
   parameter int COEFF_A_W = 12,
   parameter int COEFF_O_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 i_mode,
   input  logic                       i_valid,
   output logic                       i_ready,
   input  logic [LANES*COEFF_A_W-1:0] i_coeffs_a,
   input  logic [LANES*COEFF_O_W-1:0] i_coeffs_b,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [LANES*COEFF_O_W-1:0] o_coeffs,
   output logic                       o_last,
   output logic                       o_busy
);
   localparam int BEATS = KYBER_N / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW    = 18;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [SW-1:0]    Q_S       = SW'(KYBER_Q);

   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [1:0]                 mode_q, mode_d, mode_eff;
   logic                       beat_last, accept, s2_adv;
   logic                       s1_full_q, s1_last_q, s1_modq_q;
   logic [LANES*SW-1:0]        s1_sum_q, sum_d;
   logic                       s2_full_q, s2_last_q;
   logic [LANES*COEFF_O_W-1:0] s2_data_q, red_d;

   function automatic logic [SW-1:0] lane_sum(input logic [COEFF_A_W-1:0] a,
                                              input logic [COEFF_O_W-1:0] b,
                                              input logic                 add);
      logic [SW-1:0] a_x, b_x;
      a_x = SW'(a);
      b_x = {{(SW-COEFF_O_W){b[COEFF_O_W-1]}}, b};
      return add ? (a_x + b_x) : (a_x - b_x);
   endfunction

   // One correction step only; inputs outside [0,Q-1] are intentionally not fully reduced.
   function automatic logic [COEFF_O_W-1:0] lane_reduce(input logic [SW-1:0] s,
                                                        input logic          modq);
      logic [SW-1:0] r;
      r = s;
      if (modq) begin
         if (s[SW-1]) begin
            r = s + Q_S;
         end else if (s >= Q_S) begin
            r = s - Q_S;
         end
      end
      return r[COEFF_O_W-1:0];
   endfunction

   always_comb begin
      s2_adv    = ~s2_full_q | o_ready;
      i_ready   = ~s1_full_q | s2_adv;
      accept    = i_valid & i_ready;
      beat_last = (cnt_q == LAST_BEAT);
      mode_eff  = (cnt_q == '0) ? i_mode : mode_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      if (accept) begin
         cnt_d = beat_last ? '0 : cnt_q + 1'b1;
         if (cnt_q == '0) begin
            mode_d = i_mode;
         end
      end
   end

   always_comb begin
      sum_d = '0;
      red_d = '0;
      for (int k = 0; k < LANES; k++) begin
         sum_d[k*SW +: SW] = lane_sum(i_coeffs_a[k*COEFF_A_W +: COEFF_A_W],
                                      i_coeffs_b[k*COEFF_O_W +: COEFF_O_W], mode_eff[0]);
         red_d[k*COEFF_O_W +: COEFF_O_W] = lane_reduce(s1_sum_q[k*SW +: SW], s1_modq_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         mode_q    <= '0;
         s1_full_q <= 1'b0;
         s1_last_q <= 1'b0;
         s1_modq_q <= 1'b0;
         s1_sum_q  <= '0;
         s2_full_q <= 1'b0;
         s2_last_q <= 1'b0;
         s2_data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         if (i_ready) begin
            s1_full_q <= accept;
            if (accept) begin
               s1_sum_q  <= sum_d;
               s1_last_q <= beat_last;
               s1_modq_q <= mode_eff[1];
            end
         end
         // The stored word is kept when stage 1 is empty so o_coeffs only moves with new beats.
         if (s2_adv) begin
            s2_full_q <= s1_full_q;
            s2_last_q <= s1_full_q & s1_last_q;
            if (s1_full_q) begin
               s2_data_q <= red_d;
            end
         end
      end
   end

   assign o_valid  = s2_full_q;
   assign o_coeffs = s2_data_q;
   assign o_last   = s2_last_q;
   assign o_busy   = (cnt_q != '0) | s1_full_q | s2_full_q;

endmodule

// File: tb/tb_poly_addsub_stream.sv
// tb/tb_poly_addsub_stream.sv - directed vectors plus scoreboarded streaming sequences
module tb_poly_addsub_stream;
   localparam int BEATS = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   i_mode;
   logic         i_valid;
   logic         i_ready;
   logic [95:0]  i_coeffs_a;
   logic [127:0] i_coeffs_b;
   logic         o_valid;
   logic         o_ready;
   logic [127:0] o_coeffs;
   logic         o_last;
   logic         o_busy;

   int checks = 0;
   int errors = 0;
   int drv_beat = 0;
   int out_cnt = 0;
   int last_cnt = 0;

   logic [128:0] exp_q[$];
   int           m_cnt = 0;
   logic [1:0]   m_mode = 2'b00;
   logic [1:0]   m_eff;
   logic [128:0] m_ev;
   logic         hold_q = 1'b0;
   logic [128:0] hold_v;

   typedef struct {
      logic [1:0]   mode;
      logic [95:0]  a;
      logic [127:0] b;
      logic [127:0] e;
   } vec_t;
   vec_t vecs[6];

   poly_addsub_stream dut (
      .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .i_ready(i_ready),
      .i_coeffs_a(i_coeffs_a), .i_coeffs_b(i_coeffs_b), .o_valid(o_valid), .o_ready(o_ready),
      .o_coeffs(o_coeffs), .o_last(o_last), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_lane(input logic [1:0] m, input logic [11:0] a,
                                            input logic [15:0] b);
      int s;
      s = int'(a);
      if (m[0]) s = s + int'($signed(b));
      else      s = s - int'($signed(b));
      if (m[1]) begin
         if (s < 0) s = s + 3329;
         else if (s >= 3329) s = s - 3329;
      end
      return s[15:0];
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_cnt  = 0;
         m_mode = 2'b00;
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            checks++;
            if (!o_valid || {o_last, o_coeffs} !== hold_v) begin
               errors++;
               $display("FAIL out_stable: got v=%0b %0h expected v=1 %0h", o_valid, {o_last, o_coeffs}, hold_v);
            end
         end
         hold_q = o_valid && !o_ready;
         hold_v = {o_last, o_coeffs};
         if (o_valid && o_ready) begin
            out_cnt++;
            if (o_last) last_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_beat: got %0h expected no beat", {o_last, o_coeffs});
            end else begin
               m_ev = exp_q.pop_front();
               if ({o_last, o_coeffs} !== m_ev) begin
                  errors++;
                  $display("FAIL sb_beat: got %0h expected %0h", {o_last, o_coeffs}, m_ev);
               end
            end
         end
         if (i_valid && i_ready) begin
            m_eff = (m_cnt == 0) ? i_mode : m_mode;
            if (m_cnt == 0) m_mode = i_mode;
            for (int k = 0; k < 8; k++)
               m_ev[k*16 +: 16] = ref_lane(m_eff, i_coeffs_a[k*12 +: 12], i_coeffs_b[k*16 +: 16]);
            m_ev[128] = (m_cnt == BEATS - 1);
            m_cnt = (m_cnt + 1) % BEATS;
            exp_q.push_back(m_ev);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; drv_beat = 0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_beat(input logic [1:0] m0);
      i_mode = (drv_beat == 0) ? m0 : ~m0;
      for (int k = 0; k < 8; k++) begin
         i_coeffs_a[k*12 +: 12] = 12'($urandom_range(4095));
         if ($urandom_range(1) == 0) i_coeffs_b[k*16 +: 16] = 16'($urandom_range(3328));
         else                        i_coeffs_b[k*16 +: 16] = 16'($urandom);
      end
      i_valid = 1'b1;
   endtask

   // Called and returns at posedge+1; holds a presented beat until it is accepted.
   task automatic stream(input int nbeats, input logic [1:0] m0, input int vpct, input int rpct);
      int sent = 0;
      int cyc  = 0;
      bit acc;
      while (sent < nbeats && cyc < nbeats * 40 + 200) begin
         if (!i_valid && $urandom_range(99) < vpct) load_beat(m0);
         o_ready = ($urandom_range(99) < rpct);
         @(negedge clk);
         acc = i_valid && i_ready;
         if (acc) begin
            sent++;
            drv_beat = (drv_beat + 1) % BEATS;
         end
         @(posedge clk); #1;
         if (acc) i_valid = 1'b0;
         cyc++;
      end
      chk("stream_accepted", 128'(sent), 128'(nbeats));
   endtask

   task automatic drain();
      int n = 0;
      o_ready = 1'b1;
      i_valid = 1'b0;
      @(negedge clk);
      while ((o_valid || o_busy) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_idle", {o_valid, o_busy}, 2'b00);
      chk("drain_sb_empty", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      int o0, l0;
      logic [127:0] held;
      vecs[0].mode = 2'b00;
      vecs[0].a = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0};
      vecs[0].b = {8{16'd1}};
      vecs[0].e = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'hFFFF};
      vecs[1].mode = 2'b10;
      vecs[1].a = {12'd3000, 12'd0, 12'd100, 12'd3328, 12'd0, 12'd0, 12'd3328, 12'd5};
      vecs[1].b = {16'd5, 16'd3328, 16'd50, 16'd3328, 16'd1, 16'd0, 16'd0, 16'd3000};
      vecs[1].e = {16'd2995, 16'd1, 16'd50, 16'd0, 16'd3328, 16'd0, 16'd3328, 16'd334};
      vecs[2].mode = 2'b11;
      vecs[2].a = {12'd3328, 12'd5, 12'd3328, 12'd2000, 12'd1000, 12'd0, 12'd1, 12'd3328};
      vecs[2].b = {16'd0, 16'd6, 16'd1, 16'd2000, 16'd2000, 16'd0, 16'd3328, 16'd3328};
      vecs[2].e = {16'd3328, 16'd11, 16'd0, 16'd671, 16'd3000, 16'd0, 16'd0, 16'd3327};
      vecs[3].mode = 2'b01;
      vecs[3].a = {12'd0, 12'd4095, 12'd10, 12'd0, 12'd1, 12'd4095, 12'd0, 12'd4095};
      vecs[3].b = {16'hFFFF, 16'h0FFF, 16'd20, 16'd0, 16'd1, 16'h7FFF, 16'h8000, 16'hFFFF};
      vecs[3].e = {16'hFFFF, 16'h1FFE, 16'd30, 16'd0, 16'd2, 16'h8FFE, 16'h8000, 16'h0FFE};
      vecs[4].mode = 2'b10;
      vecs[4].a = {12'd3329, 12'd7, 12'd3328, 12'd1, 12'd4095, 12'd0, 12'd0, 12'd4095};
      vecs[4].b = {16'd0, 16'd7, 16'd3328, 16'd2, 16'hF000, 16'h7FFF, 16'h8000, 16'd0};
      vecs[4].e = {16'd0, 16'd0, 16'd0, 16'd3328, 16'd4862, 16'h8D02, 16'h72FF, 16'd766};
      vecs[5].mode = 2'b00;
      vecs[5].a = {12'd0, 12'd1, 12'd100, 12'd0, 12'd4095, 12'd0, 12'd4095, 12'd0};
      vecs[5].b = {16'd1, 16'd0, 16'd100, 16'h0FFF, 16'd0, 16'h7FFF, 16'hFFFF, 16'h8000};
      vecs[5].e = {16'hFFFF, 16'd1, 16'd0, 16'hF001, 16'h0FFF, 16'h8001, 16'h1000, 16'h8000};

      rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i_mode = 2'b00;
      i_coeffs_a = '0; i_coeffs_b = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {o_valid, o_last, o_busy, i_ready}, 4'b0001);
      chk("reset_coeffs", o_coeffs, '0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         chk("vec_reset_state", {o_valid, o_last, o_busy, i_ready}, 4'b0001);
         @(posedge clk); #1;
         i_mode = vecs[v].mode; i_coeffs_a = vecs[v].a; i_coeffs_b = vecs[v].b; i_valid = 1'b1;
         @(negedge clk);
         chk("vec_accept", 128'(i_ready), 128'd1);
         @(posedge clk); #1;
         i_valid = 1'b0;
         @(negedge clk);
         chk("vec_latency_not_yet", 128'(o_valid), 128'd0);
         @(negedge clk);
         chk("vec_valid", {o_valid, o_last}, 2'b10);
         chk("vec_coeffs", o_coeffs, vecs[v].e);
      end

      // Full polynomial back-to-back, non-first beats carry the inverted mode.
      do_reset();
      @(posedge clk); #1;
      o0 = out_cnt; l0 = last_cnt;
      stream(BEATS, 2'b10, 100, 100);
      chk("poly_busy_mid", 128'(o_busy), 128'd1);
      drain();
      chk("poly_out_count", 128'(out_cnt - o0), 128'd32);
      chk("poly_last_count", 128'(last_cnt - l0), 128'd1);

      // Backpressure for 10 cycles after 8 beats.
      do_reset();
      @(posedge clk); #1;
      o0 = out_cnt;
      stream(8, 2'b11, 100, 100);
      o_ready = 1'b0;
      load_beat(2'b11);
      @(negedge clk);
      held = o_coeffs;
      for (int c = 0; c < 10; c++) begin
         chk("bp_iready_low", {o_valid, i_ready}, 2'b10);
         chk("bp_coeffs_hold", o_coeffs, held);
         @(negedge clk);
      end
      chk("bp_buffered", 128'(exp_q.size()), 128'd2);
      @(posedge clk); #1;
      stream(BEATS - 8, 2'b11, 100, 100);
      drain();
      chk("bp_out_count", 128'(out_cnt - o0), 128'd32);

      // Asynchronous reset mid-polynomial with the pipe full.
      do_reset();
      @(posedge clk); #1;
      stream(17, 2'b10, 100, 100);
      chk("rst_pipe_full", {o_valid, o_busy, i_ready}, 3'b111);
      #2 rst = 1'b1;
      #1;
      chk("rst_immediate", {o_valid, o_busy, i_ready, o_last}, 4'b0010);
      i_valid = 1'b0;
      drv_beat = 0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      o0 = out_cnt; l0 = last_cnt;
      stream(BEATS, 2'b01, 100, 100);
      drain();
      chk("rst_new_out_count", 128'(out_cnt - o0), 128'd32);
      chk("rst_new_last_count", 128'(last_cnt - l0), 128'd1);

      // Random valid/ready/mode per polynomial.
      do_reset();
      @(posedge clk); #1;
      o0 = out_cnt;
      for (int p = 0; p < 320; p++) stream(BEATS, 2'($urandom_range(3)), 70, 70);
      drain();
      chk("rand_out_count", 128'(out_cnt - o0), 128'd10240);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
